counter_seq: RTL and testbench
==============================

# counter_seq

Command sequencer that drives the start/count-value side of the counter block and consumes its done pulse. It queues requested count values in a small FIFO and issues them one at a time: start pulse, hold value, wait for done, then the next. It sits between the control logic and the counter top, with a watchdog and sticky error flags for a counter that never finishes.

## Interface
- CNT_WIDTH, 7, width of count values; matches the counter block.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TO_WIDTH, 10, watchdog width; timeout after 2^TO_WIDTH-1 WAIT cycles.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_i  in  1  enqueue push_val_i this cycle.
- push_val_i  in  CNT_WIDTH  count value to enqueue.
- clr_i  in  1  synchronous clear of overflow_o and timeout_o.
- done_i  in  1  single-cycle done pulse from counter.
- start_o  out  1  single-cycle start pulse to counter.
- cnt_val_o  out  CNT_WIDTH  count value to counter, registered.
- full_o  out  1  FIFO holds DEPTH entries.
- empty_o  out  1  FIFO holds 0 entries.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy_o  out  1  FSM not in IDLE.
- seq_done_o  out  1  one-cycle pulse: last queued command completed.
- overflow_o  out  1  sticky: push attempted while full.
- timeout_o  out  1  sticky: watchdog expired.

## Operation
- FIFO: circular buffer, wr/rd pointers, occupancy counter 0..DEPTH. Push writes at the tail when not full. Pop happens only in ISSUE.
- Push while full: data dropped, overflow_o set. FIFO is unchanged.
- Simultaneous push and pop:
  - When not full, both occur and level is unchanged.
  - When full, the pop frees no slot for the same-cycle push. The push is dropped and overflow_o is set.
- FSM states IDLE, ISSUE, WAIT.
  - IDLE: if !empty, go to ISSUE.
  - ISSUE (exactly one cycle):
    - start_o=1.
    - cnt_val_o loaded with the FIFO head.
    - Head popped.
    - Watchdog cleared.
    - Go to WAIT.
  - WAIT:
    - Watchdog increments each cycle.
    - On done_i with queue non-empty: go to ISSUE.
    - On done_i with queue empty: go to IDLE and pulse seq_done_o in the next cycle.
    - Watchdog reaching all-ones without done_i: set timeout_o and go to IDLE. The remaining queue is kept and resumes normally.
- done_i in IDLE or ISSUE: ignored. No state change, no flag.
- cnt_val_o holds its value from ISSUE until the next ISSUE, including through IDLE.
- Value 0 is accepted and issued like any other value.
- clr_i clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- busy_o = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, FIFO empty, pointers 0, level_o=0, empty_o=1, full_o=0.
  - start_o=0, cnt_val_o=0, busy_o=0, seq_done_o=0, overflow_o=0, timeout_o=0, watchdog=0.
- rst asserted mid-operation: everything returns to reset values immediately. Queued entries are lost, and no start_o or seq_done_o is produced.
- Registered outputs: start_o, cnt_val_o, seq_done_o, overflow_o, timeout_o. Outputs decoded from registers: full_o, empty_o, level_o, busy_o.
- Push into an empty, idle block at edge N:
  - level_o=1 after N.
  - ISSUE entered at N+1, so start_o is high in cycle N+1..N+2.
  - level_o returns to 0 after N+2.
- Back-to-back commands: done_i sampled high at edge M means start_o is high in cycle M..M+1. Issue-to-issue overhead is one cycle.
- seq_done_o is high for the single cycle following the edge that sampled the final done_i.
- Timeout fires when the watchdog is 2^TO_WIDTH-1 in WAIT with no done_i. A done_i in that same cycle takes priority and timeout_o is not set.
- Level/full/empty update on the edge after push/pop.

## Test plan
- Reset check: assert rst mid-WAIT with 2 entries queued -> all outputs at reset values, empty_o=1, no start_o afterwards.
- Single command: push 5, counter model returns done_i 6 cycles after start -> one start_o pulse with cnt_val_o=5, then seq_done_o pulse, busy_o=0.
- Queue of 4 (values 3,0,7,127, DEPTH=4):
  - full_o=1 after the 4th push.
  - Starts are issued in order with values 3,0,7,127.
  - Each start_o occurs exactly 1 cycle after the preceding done_i.
  - Exactly one seq_done_o.
- Overflow: 5 pushes while stalled in WAIT -> 5th dropped, overflow_o=1, level_o stays 4. clr_i -> overflow_o=0.
- Timeout (TO_WIDTH=4): push 2 values, never return done_i -> timeout_o=1 after 15 WAIT cycles. The second value is then issued automatically. done_i during IDLE is ignored.
- Simultaneous push+pop at level 2 during ISSUE -> level_o stays 2 and FIFO order is preserved.

Source files
------------

// File: rtl/counter_seq_if.sv
// counter_seq_if: command-side and counter-side signals of the count sequencer.
interface counter_seq_if #(parameter int CNT_WIDTH = 7, parameter int DEPTH = 4);
  logic                   push_i;
  logic [CNT_WIDTH-1:0]   push_val_i;
  logic                   clr_i;
  logic                   done_i;
  logic                   start_o;
  logic [CNT_WIDTH-1:0]   cnt_val_o;
  logic                   full_o;
  logic                   empty_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   busy_o;
  logic                   seq_done_o;
  logic                   overflow_o;
  logic                   timeout_o;
  modport master (
    output push_i, push_val_i, clr_i, done_i,
    input  start_o, cnt_val_o, full_o, empty_o, level_o, busy_o, seq_done_o, overflow_o, timeout_o
  );
  modport slave (
    input  push_i, push_val_i, clr_i, done_i,
    output start_o, cnt_val_o, full_o, empty_o, level_o, busy_o, seq_done_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/counter_seq.sv
// counter_seq: queues count values and issues them one at a time to the counter,
// with a per-command watchdog and sticky overflow/timeout flags.
module counter_seq #(
    parameter int CNT_WIDTH = 7,
    parameter int DEPTH     = 4,
    parameter int TO_WIDTH  = 10
) (
    input logic clk,
    input logic rst,
    counter_seq_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr, rd;
    logic [LW-1:0]        level;
    logic [TO_WIDTH-1:0]  wd;
    logic                 full, empty, push_ok, pop, to_hit;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    // a pop in the same cycle never makes room for a push into a full FIFO
    assign push_ok = bus.push_i && !full;
    assign pop     = state == ISSUE;
    assign to_hit  = state == WAIT && !bus.done_i && &wd;

    assign bus.full_o  = full;
    assign bus.empty_o = empty;
    assign bus.level_o = level;
    assign bus.busy_o  = state != IDLE;

    always_ff @(posedge clk)
        if (push_ok) mem[wr] <= bus.push_val_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wr             <= '0;
            rd             <= '0;
            level          <= '0;
            wd             <= '0;
            bus.start_o    <= 1'b0;
            bus.cnt_val_o  <= '0;
            bus.seq_done_o <= 1'b0;
            bus.overflow_o <= 1'b0;
            bus.timeout_o  <= 1'b0;
        end else begin
            wr             <= wr + PW'(push_ok);
            rd             <= rd + PW'(pop);
            level          <= level + LW'(push_ok) - LW'(pop);
            bus.start_o    <= 1'b0;
            bus.seq_done_o <= 1'b0;
            bus.overflow_o <= (bus.push_i && full) || (bus.overflow_o && !bus.clr_i);
            bus.timeout_o  <= to_hit || (bus.timeout_o && !bus.clr_i);
            case (state)
                IDLE:
                    if (!empty) begin
                        state         <= ISSUE;
                        bus.start_o   <= 1'b1;
                        bus.cnt_val_o <= mem[rd];
                    end
                ISSUE: begin
                    state <= WAIT;
                    wd    <= '0;
                end
                WAIT:
                    if (bus.done_i && !empty) begin
                        state         <= ISSUE;
                        bus.start_o   <= 1'b1;
                        bus.cnt_val_o <= mem[rd];
                    end else if (bus.done_i) begin
                        state          <= IDLE;
                        bus.seq_done_o <= 1'b1;
                    end else if (to_hit) begin
                        state <= IDLE;
                    end else begin
                        wd <= wd + TO_WIDTH'(1);
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed and random stimulus against a queue-based reference model.
module tb_counter_seq;
    localparam int CW = 7, D = 4, TW = 4;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    counter_seq_if #(.CNT_WIDTH(CW), .DEPTH(D)) bus ();
    counter_seq #(.CNT_WIDTH(CW), .DEPTH(D), .TO_WIDTH(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0, n_bad = 0;
    int q[$];
    int ph, waited, e_start, e_cnt, e_sdone, e_ovf, e_tmo;
    int cd = 0, rmin = 6, rmax = 6;
    bit respond = 1;
    int n_start_seen = 0, n_sdone_seen = 0;
    int issued[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        ph = P_IDLE; waited = 0;
        e_start = 0; e_cnt = 0; e_sdone = 0; e_ovf = 0; e_tmo = 0;
    endfunction

    // one clock edge of the sequencer as described by its rules
    function automatic void model_step(bit push, int val, bit clr, bit done);
        bit full, ovs, tos, pop;
        full = q.size() == D;
        ovs = push && full;
        tos = 0;
        pop = ph == P_ISSUE;
        e_start = 0; e_sdone = 0;
        if (ph == P_IDLE) begin
            if (q.size() > 0) begin ph = P_ISSUE; e_start = 1; e_cnt = q[0]; end
        end else if (ph == P_ISSUE) begin
            ph = P_WAIT; waited = 0;
        end else if (done) begin
            if (q.size() > 0) begin ph = P_ISSUE; e_start = 1; e_cnt = q[0]; end
            else begin ph = P_IDLE; e_sdone = 1; end
        end else if (waited == (1 << TW) - 1) begin
            ph = P_IDLE; tos = 1;
        end else begin
            waited++;
        end
        if (pop) void'(q.pop_front());
        if (push && !full) q.push_back(val & ((1 << CW) - 1));
        e_ovf = int'(ovs || (e_ovf != 0 && !clr));
        e_tmo = int'(tos || (e_tmo != 0 && !clr));
    endfunction

    task automatic check_all(input string t);
        chk({t, ".level"}, 32'(bus.level_o), q.size());
        chk({t, ".full"}, 32'(bus.full_o), 32'(q.size() == D));
        chk({t, ".empty"}, 32'(bus.empty_o), 32'(q.size() == 0));
        chk({t, ".busy"}, 32'(bus.busy_o), 32'(ph != P_IDLE));
        chk({t, ".start"}, 32'(bus.start_o), e_start);
        chk({t, ".cnt_val"}, 32'(bus.cnt_val_o), e_cnt);
        chk({t, ".seq_done"}, 32'(bus.seq_done_o), e_sdone);
        chk({t, ".overflow"}, 32'(bus.overflow_o), e_ovf);
        chk({t, ".timeout"}, 32'(bus.timeout_o), e_tmo);
    endtask

    task automatic cyc(input string t, input bit push, input int val, input bit clr, input bit xdone);
        bit done;
        done = xdone;
        if (cd > 0) begin cd--; if (cd == 0) done = 1; end
        bus.push_i = push; bus.push_val_i = CW'(val); bus.clr_i = clr; bus.done_i = done;
        @(posedge clk);
        model_step(push, val, clr, done);
        @(negedge clk);
        check_all(t);
        if (bus.start_o) begin
            issued.push_back(int'(bus.cnt_val_o));
            if (respond) cd = $urandom_range(rmin, rmax);
        end
        n_start_seen += int'(bus.start_o);
        n_sdone_seen += int'(bus.seq_done_o);
    endtask

    task automatic idle(input string t, input int n);
        for (int i = 0; i < n; i++) cyc(t, 0, 0, 0, 0);
    endtask

    initial begin
        bus.push_i = 0; bus.push_val_i = '0; bus.clr_i = 0; bus.done_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // single command, done six cycles after start
        n_start_seen = 0; n_sdone_seen = 0;
        cyc("single", 1, 5, 0, 0);
        idle("single", 12);
        chk("single.starts", n_start_seen, 1);
        chk("single.seq_dones", n_sdone_seen, 1);

        // fill the queue behind a stalled command, then overflow and clear
        respond = 0;
        cyc("q4", 1, 9, 0, 0);
        idle("q4", 2);
        cyc("q4", 1, 3, 0, 0);
        cyc("q4", 1, 0, 0, 0);
        cyc("q4", 1, 7, 0, 0);
        cyc("q4", 1, 127, 0, 0);
        chk("q4.full_after_4", 32'(bus.full_o), 1);
        cyc("ovf", 1, 99, 0, 0);
        chk("ovf.flag", 32'(bus.overflow_o), 1);
        chk("ovf.level", 32'(bus.level_o), 4);
        cyc("ovf.clr", 0, 0, 1, 0);
        chk("ovf.cleared", 32'(bus.overflow_o), 0);
        respond = 1; rmin = 2; rmax = 2;
        issued.delete(); n_sdone_seen = 0;
        cyc("q4.drain", 0, 0, 0, 1);
        idle("q4.drain", 20);
        chk("q4.n_issued", issued.size(), 4);
        if (issued.size() == 4) begin
            chk("q4.order0", issued[0], 3);
            chk("q4.order1", issued[1], 0);
            chk("q4.order2", issued[2], 7);
            chk("q4.order3", issued[3], 127);
        end
        chk("q4.seq_dones", n_sdone_seen, 1);

        // watchdog: nothing ever answers
        respond = 0; n_start_seen = 0; n_sdone_seen = 0;
        cyc("to", 1, 11, 0, 0);
        cyc("to", 1, 22, 0, 0);
        idle("to", 45);
        chk("to.flag", 32'(bus.timeout_o), 1);
        chk("to.starts", n_start_seen, 2);
        cyc("to.idle_done", 0, 0, 0, 1);
        chk("to.idle_done_busy", 32'(bus.busy_o), 0);
        chk("to.seq_dones", n_sdone_seen, 0);
        cyc("to.clr", 0, 0, 1, 0);
        chk("to.cleared", 32'(bus.timeout_o), 0);

        // push lands in the same cycle as the ISSUE pop
        respond = 1; rmin = 4; rmax = 4; issued.delete();
        cyc("pp", 1, 40, 0, 0);
        cyc("pp", 1, 41, 0, 0);
        cyc("pp", 1, 42, 0, 0);
        chk("pp.level", 32'(bus.level_o), 2);
        idle("pp", 30);
        chk("pp.n_issued", issued.size(), 3);
        if (issued.size() == 3) begin
            chk("pp.order0", issued[0], 40);
            chk("pp.order1", issued[1], 41);
            chk("pp.order2", issued[2], 42);
        end

        // asynchronous reset while waiting with two entries queued
        respond = 0;
        cyc("rst", 1, 50, 0, 0);
        cyc("rst", 1, 51, 0, 0);
        cyc("rst", 1, 52, 0, 0);
        idle("rst", 2);
        #2 rst = 1'b1;
        #1 model_reset();
        cd = 0;
        check_all("rst.async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_start_seen = 0;
        idle("rst.after", 10);
        chk("rst.no_start", n_start_seen, 0);

        // random traffic, including late answers that trip the watchdog
        respond = 1; rmin = 1; rmax = 20;
        for (int i = 0; i < 1500; i++)
            cyc("rnd", $urandom_range(0, 9) < 3, int'($urandom_range(0, 127)),
                $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
